// File: rtl/dual_core_pkg.sv
// Shared types and constants for the dual-core memory lock arbiter.
package dual_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD0 = 2'd1,
    HELD1 = 2'd2
  } arb_state_t;

  localparam int CORE0 = 0;
  localparam int CORE1 = 1;

  localparam int              ADDR_W_DEF      = 6;
  localparam logic [5:0]      SHARED_BASE_DEF = 6'd32;

  function automatic arb_state_t held_state(input logic core);
    return core ? HELD1 : HELD0;
  endfunction

endpackage

// File: rtl/mem_lock_arbiter_if.sv
// Core-side and memory-side signals of the lock arbiter, with a debug view of the FSM state.
interface mem_lock_arbiter_if #(
  parameter int ADDR_W = 6
);
  import dual_core_pkg::*;

  logic [1:0]        need_lock;
  logic [1:0]        finished_storing;
  logic [ADDR_W-1:0] core_addr0;
  logic [ADDR_W-1:0] core_addr1;
  logic              core_wren0;
  logic              core_wren1;
  logic [1:0]        lock;
  logic              whose_turn;
  logic              wren_a;
  logic              wren_b;
  logic [1:0]        viol;
  logic              timeout;
  arb_state_t        state;

  // need_lock is a level; finished_storing is a one-cycle pulse honoured only from the holder.
  modport slave (
    input  need_lock, finished_storing, core_addr0, core_addr1, core_wren0, core_wren1,
    output lock, whose_turn, wren_a, wren_b, viol, timeout, state
  );

  modport master (
    output need_lock, finished_storing, core_addr0, core_addr1, core_wren0, core_wren1,
    input  lock, whose_turn, wren_a, wren_b, viol, timeout, state
  );

endinterface

// File: rtl/lock_hold_timer.sv
// Counts cycles the lock has been held and flags expiry at HOLD_MAX-1.
module lock_hold_timer #(
  parameter int HOLD_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign expire = run && (cnt == CNT_W'(HOLD_MAX - 1));

endmodule

// File: rtl/mem_lock_arbiter.sv
// Two-core round-robin lock with shared-region write gating.
// Optional forced release after HOLD_MAX cycles when LOCK_TIMEOUT_EN is defined.
module mem_lock_arbiter
  import dual_core_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SHARED_BASE = ADDR_W'(SHARED_BASE_DEF),
  parameter int                HOLD_MAX    = 64
) (
  input  logic                clk,
  input  logic                rst,
  mem_lock_arbiter_if.slave   bus
);

  arb_state_t state, state_n;
  logic       turn, turn_n;
  logic [1:0] viol_q;
  logic [1:0] lock;
  logic       holder_fin;
  logic       expire;
  logic       shared0, shared1;

  if (HOLD_MAX < 2) begin : g_hold_check
    $error("HOLD_MAX must be at least 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      turn  <= 1'b0;
    end else begin
      state <= state_n;
      turn  <= turn_n;
    end
  end

  // Only the current holder's release counts; others' pulses fall through unnoticed.
  assign holder_fin = ((state == HELD0) && bus.finished_storing[CORE0]) ||
                      ((state == HELD1) && bus.finished_storing[CORE1]);

  always_comb begin
    state_n = state;
    turn_n  = turn;
    case (state)
      IDLE: begin
        if (bus.need_lock == 2'b11)      state_n = held_state(turn);
        else if (bus.need_lock[CORE0])   state_n = HELD0;
        else if (bus.need_lock[CORE1])   state_n = HELD1;
      end
      HELD0: begin
        if (holder_fin || expire) begin
          state_n = IDLE;
          turn_n  = 1'b1;
        end
      end
      HELD1: begin
        if (holder_fin || expire) begin
          state_n = IDLE;
          turn_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign lock = {state == HELD1, state == HELD0};

  // Gate uses the registered lock, so a write in the grant cycle is still blocked.
  assign shared0 = (bus.core_addr0 >= SHARED_BASE);
  assign shared1 = (bus.core_addr1 >= SHARED_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_q <= 2'b00;
    end else begin
      viol_q[CORE0] <= bus.core_wren0 & shared0 & ~lock[CORE0];
      viol_q[CORE1] <= bus.core_wren1 & shared1 & ~lock[CORE1];
    end
  end

`ifdef LOCK_TIMEOUT_EN
  logic timeout_q;

  lock_hold_timer #(
    .HOLD_MAX (HOLD_MAX)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .expire (expire)
  );

  // A release landing on the expiry cycle is a normal release, not a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (expire && !holder_fin) begin
      timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.lock       = lock;
  assign bus.whose_turn = turn;
  assign bus.viol       = viol_q;
  assign bus.state      = state;
  assign bus.wren_a     = bus.core_wren0 & (~shared0 | lock[CORE0]);
  assign bus.wren_b     = bus.core_wren1 & (~shared1 | lock[CORE1]);

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed plus randomized checks of mem_lock_arbiter against a holder/turn reference model.
module tb_mem_lock_arbiter;

  localparam int ADDR_W   = 6;
  localparam int SHARED   = 32;
  localparam int HOLD_MAX = 8;
`ifdef LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  // Reference model: who holds the lock (-1 none), priority, held-cycle count.
  int         m_holder;
  logic       m_turn;
  int         m_cnt;
  logic       m_to;
  logic [1:0] m_viol;

  logic [5:0] exp_q[$];

  mem_lock_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_lock_arbiter #(
    .ADDR_W      (ADDR_W),
    .SHARED_BASE (6'd32),
    .HOLD_MAX    (HOLD_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] m_lock();
    if (m_holder == 0) return 2'b01;
    if (m_holder == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_turn   = 1'b0;
    m_cnt    = 0;
    m_to     = 1'b0;
    m_viol   = 2'b00;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    logic [5:0] e;
    exp_q.push_back({m_to, m_viol, m_turn, m_lock()});
    e = exp_q.pop_front();
    check({tag, ".lock"},       8'(bus.lock),       8'(e[1:0]));
    check({tag, ".whose_turn"}, 8'(bus.whose_turn), 8'(e[2]));
    check({tag, ".viol"},       8'(bus.viol),       8'(e[4:3]));
    check({tag, ".timeout"},    8'(bus.timeout),    8'(e[5]));
  endtask

  // One clock of stimulus: drive, check gated enables, advance model, check registers.
  task automatic step(input string tag, input logic [1:0] need, input logic [1:0] fin,
                      input logic [5:0] a0, input logic w0,
                      input logic [5:0] a1, input logic w1);
    logic       ea, eb;
    logic [1:0] nv;
    bus.need_lock        = need;
    bus.finished_storing = fin;
    bus.core_addr0       = a0;
    bus.core_wren0       = w0;
    bus.core_addr1       = a1;
    bus.core_wren1       = w1;
    #1;
    ea = w0 && ((int'(a0) < SHARED) || m_holder == 0);
    eb = w1 && ((int'(a1) < SHARED) || m_holder == 1);
    check({tag, ".wren_a"}, 8'(bus.wren_a), 8'(ea));
    check({tag, ".wren_b"}, 8'(bus.wren_b), 8'(eb));
    nv[0] = w0 && (int'(a0) >= SHARED) && (m_holder != 0);
    nv[1] = w1 && (int'(a1) >= SHARED) && (m_holder != 1);
    @(posedge clk);
    m_viol = nv;
    if (m_holder < 0) begin
      m_cnt = 0;
      if (need == 2'b11)  m_holder = int'(m_turn);
      else if (need[0])   m_holder = 0;
      else if (need[1])   m_holder = 1;
    end else if (fin[m_holder]) begin
      m_turn   = (m_holder == 0);
      m_holder = -1;
      m_cnt    = 0;
    end else if (TO_EN && m_cnt == HOLD_MAX - 1) begin
      m_turn   = (m_holder == 0);
      m_holder = -1;
      m_cnt    = 0;
      m_to     = 1'b1;
    end else begin
      m_cnt++;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle_step(input string tag, input logic [1:0] need, input logic [1:0] fin);
    step(tag, need, fin, 6'd0, 1'b0, 6'd0, 1'b0);
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.need_lock        = 2'b00;
    bus.finished_storing = 2'b00;
    bus.core_addr0       = '0;
    bus.core_addr1       = '0;
    bus.core_wren0       = 1'b0;
    bus.core_wren1       = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs("reset");

    // Simple grant and release by core0.
    idle_step("grant0", 2'b01, 2'b00);
    idle_step("rel0",   2'b00, 2'b01);

    // Bring priority back to core0, then contend.
    idle_step("grant1", 2'b10, 2'b00);
    idle_step("rel1",   2'b00, 2'b10);
    idle_step("contend", 2'b11, 2'b00);
    idle_step("handoff_gap", 2'b10, 2'b01);
    idle_step("handoff_grant", 2'b10, 2'b00);
    idle_step("rel1b", 2'b00, 2'b10);

    // Unlocked shared write is blocked and flagged; unshared passes.
    step("viol_shared",   2'b00, 2'b00, 6'd0, 1'b0, 6'd40, 1'b1);
    step("noviol_unshar", 2'b00, 2'b00, 6'd0, 1'b0, 6'd5,  1'b1);
    step("boundary31",    2'b00, 2'b00, 6'd31, 1'b1, 6'd32, 1'b1);
    step("boundary63",    2'b00, 2'b00, 6'd63, 1'b1, 6'd0,  1'b0);

    // Non-holder release ignored.
    idle_step("grant0b", 2'b01, 2'b00);
    idle_step("foreign_rel", 2'b00, 2'b10);
    idle_step("rel0b", 2'b00, 2'b01);

    // Request and release together in IDLE: request wins.
    idle_step("req_rel_same", 2'b01, 2'b01);
    idle_step("rel0c", 2'b00, 2'b01);

    // Write in the grant cycle is blocked; once held it passes.
    step("grant_cycle_wr", 2'b01, 2'b00, 6'd40, 1'b1, 6'd0, 1'b0);
    step("held_wr",        2'b00, 2'b00, 6'd40, 1'b1, 6'd0, 1'b0);

    // Long hold without release: times out only when the feature is built in.
    for (int i = 0; i < 10; i++) idle_step("long_hold", 2'b00, 2'b00);
    idle_step("long_rel", 2'b00, 2'b01);

    // Asynchronous reset mid-hold.
    idle_step("grant1c", 2'b10, 2'b00);
    idle_step("hold1c",  2'b10, 2'b00);
    #4;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst.lock",       8'(bus.lock),       8'(m_lock()));
    check("async_rst.whose_turn", 8'(bus.whose_turn), 8'(m_turn));
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_regs("after_rst");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] need, fin;
      need = 2'($urandom_range(0, 3));
      fin  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step("rand", need, fin,
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
